merge_pass_sched: RTL

//  Sequences the log2(N) merge passes of the ping-pong merge sort over one shared merge stage.
//  Per pass it issues the ap_* handshake to the merge stage, presents the run width, and selects the read/write banks.

---
 rtl/merge_pass_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/merge_pass_sched.sv
// Pass scheduler for the ping-pong merge sort: runs LOG2N merge passes over one shared
// merge stage, alternating banks each pass, with a per-pass stall watchdog.
module merge_pass_sched #(
   parameter int N     = 16,
   parameter int LOG2N = 4,
   parameter int TMO_W = 10
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             ap_ready,
   input  logic             ap_continue,
   output logic             mrg_start,
   input  logic             mrg_ready,
   input  logic             mrg_done,
   output logic             mrg_continue,
   output logic [LOG2N-1:0] mrg_width,
   output logic             rd_bank,
   output logic             wr_bank,
   output logic [LOG2N-1:0] pass_idx,
   output logic             result_bank,
   output logic             err
);

   localparam logic [4:0] S_IDLE   = 5'b00001;
   localparam logic [4:0] S_LAUNCH = 5'b00010;
   localparam logic [4:0] S_WAIT   = 5'b00100;
   localparam logic [4:0] S_NEXT   = 5'b01000;
   localparam logic [4:0] S_DONE   = 5'b10000;

   localparam int               HALF_N    = N / 2;
   localparam logic [LOG2N-1:0] W_ONE     = {{(LOG2N-1){1'b0}}, 1'b1};
   localparam logic [LOG2N-1:0] W_LAST    = HALF_N[LOG2N-1:0];
   // Timeout fires on the cycle the counter would reach all-ones.
   localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

   logic [4:0]       r_state;
   logic             r_done;
   logic             r_ready;
   logic [TMO_W-1:0] r_tmo;
   logic [LOG2N-1:0] r_pass;
   logic [LOG2N-1:0] r_width;
   logic             r_rd_bank;
   logic             r_result;
   logic             r_err;

   logic w_in_launch;
   logic w_in_wait;
   logic w_last_pass;

   assign w_in_launch = (r_state == S_LAUNCH);
   assign w_in_wait   = (r_state == S_WAIT);
   // The final pass is the one merging runs of N/2.
   assign w_last_pass = (r_width == W_LAST);

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_state   <= S_IDLE;
         r_done    <= 1'b0;
         r_ready   <= 1'b0;
         r_tmo     <= '0;
         r_pass    <= '0;
         r_width   <= W_ONE;
         r_rd_bank <= 1'b0;
         r_result  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ap_start && !r_done) begin
                  r_state   <= S_LAUNCH;
                  r_pass    <= '0;
                  r_width   <= W_ONE;
                  r_rd_bank <= 1'b0;
                  r_err     <= 1'b0;
                  r_tmo     <= '0;
               end
            end
            S_LAUNCH: begin
               if (mrg_ready) begin
                  r_state <= mrg_done ? S_NEXT : S_WAIT;
               end
            end
            S_WAIT: begin
               r_tmo <= r_tmo + 1'b1;
               if (mrg_done) begin
                  r_state <= S_NEXT;
               end else if (r_tmo == TMO_LAST) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_NEXT: begin
               r_tmo <= '0;
               if (w_last_pass) begin
                  r_result <= ~r_rd_bank;
                  r_done   <= 1'b1;
                  r_ready  <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_pass    <= r_pass + 1'b1;
                  r_width   <= r_width << 1;
                  r_rd_bank <= ~r_rd_bank;
                  r_state   <= S_LAUNCH;
               end
            end
            S_DONE: begin
               if (ap_continue) begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mrg_start    = w_in_launch;
   assign mrg_continue = (w_in_launch && mrg_ready && mrg_done) || (w_in_wait && mrg_done);
   assign ap_idle      = (r_state == S_IDLE) && !ap_start;
   assign ap_done      = r_done;
   assign ap_ready     = r_ready;
   assign mrg_width    = r_width;
   assign rd_bank      = r_rd_bank;
   assign wr_bank      = ~r_rd_bank;
   assign pass_idx     = r_pass;
   assign result_bank  = r_result;
   assign err          = r_err;

endmodule
